// File: rtl/messenger_mc.sv
// Multi-channel ring messenger: sends CPU messages onto the ring when holding the token,
// and sorts received messages into per-type receive FIFOs with overflow admission control.
module messenger_mc #(
   parameter int CORE_W   = 4,
   parameter int LEN_W    = 6,
   parameter int NCHAN    = 4,
   parameter int MQ_DEPTH = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [3+LEN_W+CORE_W:0]   aq,
   input  logic                      read,
   input  logic [31:0]               wq,
   output logic                      rwq,
   output logic [31:0]               rqMsgr,
   output logic                      wrq,
   output logic                      done,
   input  logic                      selMsgr,
   input  logic [CORE_W-1:0]         whichCore,
   input  logic [31:0]               RingIn,
   input  logic [3:0]                SlotTypeIn,
   input  logic [CORE_W-1:0]         SourceIn,
   output logic [31:0]               msgrRingOut,
   output logic [3:0]                msgrSlotTypeOut,
   output logic [CORE_W-1:0]         msgrSourceOut,
   output logic                      msgrDriveRing,
   output logic                      msgrWantsToken,
   input  logic                      msgrAcquireToken,
   output logic                      ctrlValid,
   output logic [3:0]                ctrlType,
   output logic [CORE_W-1:0]         ctrlSrc,
   output logic [15:0]               dropCount,
   output logic [NCHAN-1:0]          chanNonEmpty
);

   localparam logic [3:0] SLOT_MESSAGE = 4'h1;
   localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int AW  = $clog2(MQ_DEPTH);
   localparam logic [CHW-1:0]   CHAN_MASK = CHW'(NCHAN - 1);
   localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] WAIT_TOKEN = 3'd1;
   localparam logic [2:0] SEND       = 3'd2;
   localparam logic [2:0] COPY_HDR   = 3'd3;
   localparam logic [2:0] COPY_PAY   = 3'd4;

   function automatic logic [CHW-1:0] chan_of(input logic [3:0] msg_type);
      return CHW'(msg_type) & CHAN_MASK;
   endfunction

   logic [CORE_W-1:0] aq_dest;
   logic [LEN_W-1:0]  aq_len;
   logic [3:0]        aq_type;
   logic [CHW-1:0]    aq_chan;
   logic [31:0]       tx_hdr;

   assign aq_dest = aq[CORE_W-1:0];
   assign aq_len  = aq[CORE_W +: LEN_W];
   assign aq_type = aq[CORE_W+LEN_W +: 4];
   assign aq_chan = chan_of(aq_type);
   assign tx_hdr  = 32'({aq_dest, whichCore, aq_type, aq_len});

   logic [31:0] mem [NCHAN][MQ_DEPTH];
   logic [AW:0] wr_ptr [NCHAN];
   logic [AW:0] rd_ptr [NCHAN];
   logic [AW:0] fill [NCHAN];
   logic [NCHAN-1:0] non_empty;

   always_comb begin
      for (int c = 0; c < NCHAN; c++) begin
         fill[c]      = wr_ptr[c] - rd_ptr[c];
         non_empty[c] = (fill[c] != '0);
      end
   end

   logic [LEN_W-1:0]  hdr_len;
   logic [3:0]        hdr_type;
   logic [CORE_W-1:0] hdr_src;
   logic [CORE_W-1:0] hdr_dest;
   logic [CHW-1:0]    hdr_chan;
   logic [LEN_W-1:0]  in_len;
   logic              rx_active;
   logic [CHW-1:0]    rx_chan;
   logic              is_msg, is_hdr, for_us, accept, room, admit, drop;
   logic              wr_en;
   logic [CHW-1:0]    wr_chan;

   assign hdr_len  = RingIn[LEN_W-1:0];
   assign hdr_type = RingIn[LEN_W +: 4];
   assign hdr_src  = RingIn[LEN_W+4 +: CORE_W];
   assign hdr_dest = RingIn[LEN_W+4+CORE_W +: CORE_W];
   assign hdr_chan = chan_of(hdr_type);

   // Headers are only recognised between messages, so payload words never look like headers.
   assign is_msg = (SlotTypeIn == SLOT_MESSAGE);
   assign is_hdr = is_msg && (in_len == '0);
   assign for_us = ((hdr_dest == whichCore) && (hdr_src != hdr_dest)) ||
                   ((hdr_src == hdr_dest) && (hdr_dest != whichCore));
   assign accept = is_hdr && for_us;
   assign room   = (32'(MQ_DEPTH) - 32'(fill[hdr_chan])) >= (32'(hdr_len) + 32'd1);
   assign admit  = accept && (hdr_len != '0) && room;
   assign drop   = accept && (hdr_len != '0) && !room;
   assign wr_en  = admit || (rx_active && is_msg && (in_len != '0));
   assign wr_chan = admit ? hdr_chan : rx_chan;

   assign ctrlValid = accept && (hdr_len == '0);
   assign ctrlType  = ctrlValid ? hdr_type : 4'd0;
   assign ctrlSrc   = ctrlValid ? hdr_src : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         in_len    <= '0;
         rx_active <= 1'b0;
         rx_chan   <= '0;
         dropCount <= 16'd0;
      end else begin
         if (is_hdr) begin
            in_len    <= hdr_len;
            rx_active <= admit;
         end else if (is_msg && (in_len != '0)) begin
            in_len <= in_len - LEN_ONE;
            if (in_len == LEN_ONE) rx_active <= 1'b0;
         end
         if (admit) rx_chan <= hdr_chan;
         if (drop && (dropCount != 16'hFFFF)) dropCount <= dropCount + 16'd1;
      end
   end

   logic [2:0]       state, next_state;
   logic [LEN_W-1:0] len_cnt;
   logic [CHW-1:0]   sel_chan;
   logic [CHW-1:0]   cur_chan;
   logic [31:0]      rd_head;
   logic             rd_en;

   assign cur_chan = (state == IDLE) ? aq_chan : sel_chan;
   assign rd_head  = mem[cur_chan][rd_ptr[cur_chan][AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int c = 0; c < NCHAN; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
      end else begin
         if (wr_en) wr_ptr[wr_chan] <= wr_ptr[wr_chan] + PTR_ONE;
         if (rd_en) rd_ptr[cur_chan] <= rd_ptr[cur_chan] + PTR_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_chan][wr_ptr[wr_chan][AW-1:0]] <= RingIn;
   end

   // COPY_PAY stalls if the payload has not fully arrived yet.
   always_comb begin
      next_state     = state;
      rwq            = 1'b0;
      wrq            = 1'b0;
      done           = 1'b0;
      rqMsgr         = 32'd0;
      msgrRingOut    = 32'd0;
      msgrDriveRing  = 1'b0;
      msgrWantsToken = 1'b0;
      rd_en          = 1'b0;
      case (state)
         IDLE: begin
            if (selMsgr) begin
               if (!read) begin
                  next_state = WAIT_TOKEN;
               end else if (!non_empty[aq_chan]) begin
                  wrq  = 1'b1;
                  done = 1'b1;
               end else begin
                  next_state = COPY_HDR;
               end
            end
         end
         WAIT_TOKEN: begin
            msgrWantsToken = 1'b1;
            if (msgrAcquireToken) begin
               msgrDriveRing = 1'b1;
               msgrRingOut   = tx_hdr;
               if (aq_len == '0) begin
                  done       = 1'b1;
                  next_state = IDLE;
               end else begin
                  next_state = SEND;
               end
            end
         end
         SEND: begin
            rwq           = 1'b1;
            msgrRingOut   = wq;
            msgrDriveRing = 1'b1;
            if (len_cnt == LEN_ONE) begin
               done       = 1'b1;
               next_state = IDLE;
            end
         end
         COPY_HDR: begin
            wrq        = 1'b1;
            rqMsgr     = rd_head;
            rd_en      = 1'b1;
            next_state = COPY_PAY;
         end
         COPY_PAY: begin
            if (non_empty[sel_chan]) begin
               wrq    = 1'b1;
               rqMsgr = rd_head;
               rd_en  = 1'b1;
               if (len_cnt == LEN_ONE) begin
                  done       = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         len_cnt  <= '0;
         sel_chan <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE:       if (selMsgr && read) sel_chan <= aq_chan;
            WAIT_TOKEN: if (msgrAcquireToken) len_cnt <= aq_len;
            SEND:       len_cnt <= len_cnt - LEN_ONE;
            COPY_HDR:   len_cnt <= rd_head[LEN_W-1:0];
            COPY_PAY:   if (non_empty[sel_chan]) len_cnt <= len_cnt - LEN_ONE;
            default:    ;
         endcase
      end
   end

   logic unused_source;
   assign unused_source = ^SourceIn;

   assign msgrSlotTypeOut = SLOT_MESSAGE;
   assign msgrSourceOut   = whichCore;
   assign chanNonEmpty    = non_empty;

endmodule

// File: tb/tb_messenger_mc.sv
// Directed self-checking bench for messenger_mc: send path, receive sorting,
// channel reads, control messages, overflow drops, broadcast filtering and reset.
module tb_messenger_mc;

   localparam int CORE_W   = 4;
   localparam int LEN_W    = 6;
   localparam int NCHAN    = 4;
   localparam int MQ_DEPTH = 64;
   localparam logic [3:0] SLOT_MSG = 4'h1;

   logic              clock = 1'b0;
   logic              reset;
   logic [3+LEN_W+CORE_W:0] aq;
   logic              read;
   logic [31:0]       wq;
   logic              rwq;
   logic [31:0]       rqMsgr;
   logic              wrq;
   logic              done;
   logic              selMsgr;
   logic [CORE_W-1:0] whichCore;
   logic [31:0]       RingIn;
   logic [3:0]        SlotTypeIn;
   logic [CORE_W-1:0] SourceIn;
   logic [31:0]       msgrRingOut;
   logic [3:0]        msgrSlotTypeOut;
   logic [CORE_W-1:0] msgrSourceOut;
   logic              msgrDriveRing;
   logic              msgrWantsToken;
   logic              msgrAcquireToken;
   logic              ctrlValid;
   logic [3:0]        ctrlType;
   logic [CORE_W-1:0] ctrlSrc;
   logic [15:0]       dropCount;
   logic [NCHAN-1:0]  chanNonEmpty;

   int checks = 0;
   int errors = 0;

   messenger_mc #(.CORE_W(CORE_W), .LEN_W(LEN_W), .NCHAN(NCHAN), .MQ_DEPTH(MQ_DEPTH)) dut (
      .clock(clock), .reset(reset), .aq(aq), .read(read), .wq(wq), .rwq(rwq),
      .rqMsgr(rqMsgr), .wrq(wrq), .done(done), .selMsgr(selMsgr), .whichCore(whichCore),
      .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
      .msgrRingOut(msgrRingOut), .msgrSlotTypeOut(msgrSlotTypeOut),
      .msgrSourceOut(msgrSourceOut), .msgrDriveRing(msgrDriveRing),
      .msgrWantsToken(msgrWantsToken), .msgrAcquireToken(msgrAcquireToken),
      .ctrlValid(ctrlValid), .ctrlType(ctrlType), .ctrlSrc(ctrlSrc),
      .dropCount(dropCount), .chanNonEmpty(chanNonEmpty)
   );

   always #5 clock = ~clock;

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic endCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] slot, input logic [31:0] data);
      SlotTypeIn = slot;
      RingIn     = data;
      endCycle();
   endtask

   initial begin
      reset = 1'b1; aq = '0; read = 1'b0; wq = 32'd0; selMsgr = 1'b0;
      whichCore = 4'd2; RingIn = 32'd0; SlotTypeIn = 4'd0; SourceIn = 4'd0;
      msgrAcquireToken = 1'b0;
      endCycle();
      endCycle();
      reset = 1'b0;
      #2;
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_wrq", 32'(wrq), 32'd0);
      checkOutput("rst_drive", 32'(msgrDriveRing), 32'd0);
      checkOutput("rst_drop", 32'(dropCount), 32'd0);
      checkOutput("rst_nonempty", 32'(chanNonEmpty), 32'd0);
      checkOutput("rst_slottype", 32'(msgrSlotTypeOut), 32'd1);
      checkOutput("rst_source", 32'(msgrSourceOut), 32'd2);
      endCycle();

      // Send type 3, len 2, dest 5 from core 2
      aq = {4'd3, 6'd2, 4'd5}; selMsgr = 1'b1; read = 1'b0;
      #2;
      checkOutput("send_idle_want", 32'(msgrWantsToken), 32'd0);
      endCycle();
      #2;
      checkOutput("send_want", 32'(msgrWantsToken), 32'd1);
      checkOutput("send_nodrive", 32'(msgrDriveRing), 32'd0);
      endCycle();
      msgrAcquireToken = 1'b1;
      #2;
      checkOutput("send_hdr_drive", 32'(msgrDriveRing), 32'd1);
      checkOutput("send_hdr", msgrRingOut, 32'h000148C2);
      checkOutput("send_hdr_done", 32'(done), 32'd0);
      endCycle();
      msgrAcquireToken = 1'b0; wq = 32'hAAAA0001;
      #2;
      checkOutput("send_w0_rwq", 32'(rwq), 32'd1);
      checkOutput("send_w0_data", msgrRingOut, 32'hAAAA0001);
      checkOutput("send_w0_done", 32'(done), 32'd0);
      endCycle();
      wq = 32'hAAAA0002; selMsgr = 1'b0;
      #2;
      checkOutput("send_w1_rwq", 32'(rwq), 32'd1);
      checkOutput("send_w1_data", msgrRingOut, 32'hAAAA0002);
      checkOutput("send_w1_done", 32'(done), 32'd1);
      endCycle();
      #2;
      checkOutput("send_after_rwq", 32'(rwq), 32'd0);
      checkOutput("send_after_drive", 32'(msgrDriveRing), 32'd0);

      // Receive dest 2, src 7, type 1, len 3 into channel 1
      applyStimulus(SLOT_MSG, 32'h00009C43);
      applyStimulus(SLOT_MSG, 32'h00000011);
      applyStimulus(SLOT_MSG, 32'h00000022);
      applyStimulus(SLOT_MSG, 32'h00000033);
      applyStimulus(4'd0, 32'd0);
      #2;
      checkOutput("rx_nonempty", 32'(chanNonEmpty), 32'h2);
      endCycle();

      aq = {4'd1, 6'd0, 4'd0}; selMsgr = 1'b1; read = 1'b1;
      #2;
      checkOutput("rd1_idle_wrq", 32'(wrq), 32'd0);
      endCycle();
      selMsgr = 1'b0; aq = '0;
      #2;
      checkOutput("rd1_hdr_wrq", 32'(wrq), 32'd1);
      checkOutput("rd1_hdr", rqMsgr, 32'h00009C43);
      endCycle();
      #2;
      checkOutput("rd1_p0", rqMsgr, 32'h11);
      checkOutput("rd1_p0_done", 32'(done), 32'd0);
      endCycle();
      #2;
      checkOutput("rd1_p1", rqMsgr, 32'h22);
      endCycle();
      #2;
      checkOutput("rd1_p2", rqMsgr, 32'h33);
      checkOutput("rd1_p2_wrq", 32'(wrq), 32'd1);
      checkOutput("rd1_p2_done", 32'(done), 32'd1);
      endCycle();
      #2;
      checkOutput("rd1_after_wrq", 32'(wrq), 32'd0);
      checkOutput("rd1_nonempty", 32'(chanNonEmpty), 32'd0);

      // Read of empty channel 0 completes in the same cycle
      aq = {4'd0, 6'd0, 4'd0}; selMsgr = 1'b1; read = 1'b1;
      #2;
      checkOutput("rd0_wrq", 32'(wrq), 32'd1);
      checkOutput("rd0_data", rqMsgr, 32'd0);
      checkOutput("rd0_done", 32'(done), 32'd1);
      endCycle();
      selMsgr = 1'b0;
      #2;
      checkOutput("rd0_stay_idle", 32'(wrq), 32'd0);
      endCycle();

      // Zero-length control message: dest 2, src 4, type 9
      SlotTypeIn = SLOT_MSG; RingIn = 32'h00009240;
      #2;
      checkOutput("ctrl_valid", 32'(ctrlValid), 32'd1);
      checkOutput("ctrl_type", 32'(ctrlType), 32'd9);
      checkOutput("ctrl_src", 32'(ctrlSrc), 32'd4);
      endCycle();
      SlotTypeIn = 4'd0; RingIn = 32'd0;
      #2;
      checkOutput("ctrl_pulse_end", 32'(ctrlValid), 32'd0);
      checkOutput("ctrl_no_fifo", 32'(chanNonEmpty), 32'd0);
      endCycle();

      // Fill channel 2 with 12 messages of 5 words (60 words)
      for (int m = 0; m < 12; m++) begin
         applyStimulus(SLOT_MSG, 32'h00009C84);
         for (int w = 0; w < 4; w++) applyStimulus(SLOT_MSG, 32'h20000000 | 32'(m * 16 + w));
      end
      // len 5 needs 6 free words, only 4 remain
      SlotTypeIn = SLOT_MSG; RingIn = 32'h00009C85;
      #2;
      checkOutput("drop_hdr_ctrl", 32'(ctrlValid), 32'd0);
      endCycle();
      for (int w = 0; w < 5; w++) begin
         RingIn = 32'h00009240;
         #2;
         checkOutput("drop_payload_not_hdr", 32'(ctrlValid), 32'd0);
         endCycle();
      end
      RingIn = 32'h00009580;
      #2;
      checkOutput("drop_count1", 32'(dropCount), 32'd1);
      checkOutput("after_drop_ctrl_valid", 32'(ctrlValid), 32'd1);
      checkOutput("after_drop_ctrl_type", 32'(ctrlType), 32'd6);
      checkOutput("after_drop_ctrl_src", 32'(ctrlSrc), 32'd5);
      endCycle();
      // len 3 fits exactly into the 4 remaining words
      applyStimulus(SLOT_MSG, 32'h00009C83);
      for (int w = 0; w < 3; w++) applyStimulus(SLOT_MSG, 32'h30000000 | 32'(w));
      applyStimulus(4'd0, 32'd0);
      #2;
      checkOutput("exact_fit_admitted", 32'(dropCount), 32'd1);
      applyStimulus(SLOT_MSG, 32'h00009C81);
      applyStimulus(SLOT_MSG, 32'h40000000);
      applyStimulus(4'd0, 32'd0);
      #2;
      checkOutput("full_drop_count2", 32'(dropCount), 32'd2);
      checkOutput("full_nonempty", 32'(chanNonEmpty), 32'h4);
      endCycle();

      // Oldest message of channel 2 comes out first
      aq = {4'd2, 6'd0, 4'd0}; selMsgr = 1'b1; read = 1'b1;
      endCycle();
      selMsgr = 1'b0;
      #2;
      checkOutput("rd2_hdr", rqMsgr, 32'h00009C84);
      endCycle();
      for (int w = 0; w < 4; w++) begin
         #2;
         checkOutput("rd2_payload", rqMsgr, 32'h20000000 | 32'(w));
         checkOutput("rd2_done", 32'(done), (w == 3) ? 32'd1 : 32'd0);
         endCycle();
      end
      #2;
      checkOutput("rd2_after_wrq", 32'(wrq), 32'd0);

      // Broadcast from core 3 accepted; broadcast from own id and foreign traffic ignored
      applyStimulus(SLOT_MSG, 32'h0000CCC1);
      applyStimulus(SLOT_MSG, 32'h00000077);
      applyStimulus(4'd0, 32'd0);
      #2;
      checkOutput("bcast3_accept", 32'(chanNonEmpty), 32'hC);
      applyStimulus(SLOT_MSG, 32'h00008801);
      applyStimulus(SLOT_MSG, 32'h00000088);
      applyStimulus(4'd0, 32'd0);
      #2;
      checkOutput("bcast2_ignored", 32'(chanNonEmpty), 32'hC);
      applyStimulus(SLOT_MSG, 32'h00015C01);
      applyStimulus(SLOT_MSG, 32'h00000099);
      applyStimulus(4'd0, 32'd0);
      #2;
      checkOutput("foreign_ignored", 32'(chanNonEmpty), 32'hC);

      // Reset during COPY_PAY while a channel-0 message is half received
      aq = {4'd2, 6'd0, 4'd0}; selMsgr = 1'b1; read = 1'b1;
      SlotTypeIn = SLOT_MSG; RingIn = 32'h00009C03;
      endCycle();
      selMsgr = 1'b0; RingIn = 32'h00000001;
      #2;
      checkOutput("rst_test_hdr", rqMsgr, 32'h00009C84);
      endCycle();
      RingIn = 32'h00000002; reset = 1'b1;
      #2;
      checkOutput("rst_test_pay_wrq", 32'(wrq), 32'd1);
      endCycle();
      reset = 1'b0; RingIn = 32'h00009240;
      #2;
      checkOutput("midrst_wrq", 32'(wrq), 32'd0);
      checkOutput("midrst_nonempty", 32'(chanNonEmpty), 32'd0);
      checkOutput("midrst_drop", 32'(dropCount), 32'd0);
      checkOutput("midrst_inlen_clear", 32'(ctrlValid), 32'd1);
      endCycle();
      SlotTypeIn = 4'd0; RingIn = 32'd0;
      #2;
      checkOutput("midrst_done", 32'(done), 32'd0);
      checkOutput("midrst_nonempty2", 32'(chanNonEmpty), 32'd0);
      endCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
